// File: rtl/dg_multi_ch.sv
// -----------------------------------------------------------------------------
// dg_multi_ch
// Multi-channel packet descriptor generator. Each channel runs its own small
// FSM (IDLE/SEND/GAP/DONE) and emits i_pkt_num descriptors to its downstream
// FIFO over a valid/ready handshake. Descriptors follow either an incrementing
// pattern or a per-channel 16-bit Galois LFSR.
//
// Descriptor word: {zero pad, wait[WAIT_W], len[LEN_W], prior[PRIOR_W], da[DA_W]}
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_start         start pulse, accepted only while every channel is idle
//   i_mode          0 = incrementing, 1 = LFSR (latched on accepted start)
//   i_pkt_num       descriptors per channel (latched on accepted start)
//   i_gap           idle cycles after each handshake (latched on accepted start)
//   o_busy          high from accepted start through the o_done cycle
//   o_done          one-cycle pulse once every channel has finished
//   i_fifo_ready    per-channel downstream ready
//   o_fifo_vld      per-channel valid
//   o_fifo_data     channel c at [c*DATA_WIDTH +: DATA_WIDTH]
// -----------------------------------------------------------------------------
module dg_multi_ch #(
    parameter int          NUM_CH     = 4,
    parameter int          DATA_WIDTH = 32,
    parameter int          DA_W       = 4,
    parameter int          PRIOR_W    = 3,
    parameter int          LEN_W      = 10,
    parameter int          WAIT_W     = 10,
    parameter int          CNT_W      = 8,
    parameter int          GAP_W      = 8,
    parameter int          LEN_STEP   = 10,
    parameter int          WAIT_STEP  = 10,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    input  logic                         i_mode,
    input  logic [CNT_W-1:0]             i_pkt_num,
    input  logic [GAP_W-1:0]             i_gap,
    output logic                         o_busy,
    output logic                         o_done,
    input  logic [NUM_CH-1:0]            i_fifo_ready,
    output logic [NUM_CH-1:0]            o_fifo_vld,
    output logic [NUM_CH*DATA_WIDTH-1:0] o_fifo_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Galois LFSR, taps 0xB400, shifting right.
    function automatic logic [15:0] f_lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    // An all-zero state would lock the LFSR, so a zero seed becomes 1.
    function automatic logic [15:0] f_seed(input int c);
        logic [15:0] s;
        s = LFSR_SEED + 16'(c);
        if (s == 16'd0) s = 16'd1;
        return s;
    endfunction

    // Assemble a descriptor word; a zero length is never emitted.
    function automatic logic [DATA_WIDTH-1:0] f_pack(
        input logic [WAIT_W-1:0]  wt,
        input logic [LEN_W-1:0]   ln,
        input logic [PRIOR_W-1:0] pr,
        input logic [DA_W-1:0]    da
    );
        logic [DATA_WIDTH-1:0] w;
        logic [LEN_W-1:0]      l;
        l = ln;
        if (l == '0) l = LEN_W'(1);
        w = '0;
        w[DA_W-1:0]                          = da;
        w[DA_W +: PRIOR_W]                   = pr;
        w[DA_W+PRIOR_W +: LEN_W]             = l;
        w[DA_W+PRIOR_W+LEN_W +: WAIT_W]      = wt;
        return w;
    endfunction

    // Incrementing pattern; k1 is the 1-based descriptor index.
    function automatic logic [DATA_WIDTH-1:0] f_inc_word(input int c, input logic [31:0] k1);
        return f_pack(WAIT_W'(32'd20 + 32'(WAIT_STEP) * k1),
                      LEN_W'(32'd1 + 32'(LEN_STEP) * k1),
                      PRIOR_W'(k1),
                      DA_W'(k1 + 32'(c)));
    endfunction

    function automatic logic [DATA_WIDTH-1:0] f_lfsr_word(input logic [15:0] s);
        return f_pack(s[WAIT_W-1:0] ^ s[15 -: WAIT_W],
                      s[15 -: LEN_W],
                      s[DA_W +: PRIOR_W],
                      s[DA_W-1:0]);
    endfunction

    logic              r_mode;
    logic [CNT_W-1:0]  r_pkt_num;
    logic [GAP_W-1:0]  r_gap;
    logic [NUM_CH-1:0] w_idle_vec;
    logic [NUM_CH-1:0] w_done_vec;
    logic              w_idle_all;
    logic              w_done_all;
    logic              w_start_acc;

    assign w_idle_all  = &w_idle_vec;
    assign w_done_all  = &w_done_vec;
    assign w_start_acc = i_start && w_idle_all;
    assign o_busy      = !w_idle_all;
    assign o_done      = w_done_all;

    // Run configuration is captured only on an accepted start, so a start
    // pulse during a run cannot disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode    <= 1'b0;
            r_pkt_num <= '0;
            r_gap     <= '0;
        end else if (w_start_acc) begin
            r_mode    <= i_mode;
            r_pkt_num <= i_pkt_num;
            r_gap     <= i_gap;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t                r_state;
        state_t                w_state_nxt;
        logic [CNT_W-1:0]      r_cnt;
        logic [GAP_W-1:0]      r_gcnt;
        logic [15:0]           r_lfsr;
        logic [15:0]           w_lfsr_nxt;
        logic [DATA_WIDTH-1:0] r_data;
        logic                  w_hs;
        logic                  w_last;

        assign w_hs       = (r_state == S_SEND) && i_fifo_ready[c];
        assign w_last     = (r_cnt + 1'b1) == r_pkt_num;
        assign w_lfsr_nxt = f_lfsr_next(r_lfsr);

        always_comb begin
            w_state_nxt = r_state;
            case (r_state)
                S_IDLE: begin
                    if (w_start_acc) begin
                        // The count is not latched yet, so look at the input.
                        w_state_nxt = (i_pkt_num == '0) ? S_DONE : S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_hs) begin
                        if (w_last)              w_state_nxt = S_DONE;
                        else if (r_gap == '0)    w_state_nxt = S_SEND;
                        else                     w_state_nxt = S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gcnt <= GAP_W'(1)) w_state_nxt = S_SEND;
                end
                S_DONE: begin
                    if (w_done_all) w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        // The next descriptor is loaded on the handshake edge, so data only
        // changes after it has been accepted and stays put while stalled.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_gcnt  <= '0;
                r_lfsr  <= f_seed(c);
                r_data  <= '0;
            end else begin
                r_state <= w_state_nxt;
                if (w_start_acc) begin
                    r_cnt  <= '0;
                    r_data <= i_mode ? f_lfsr_word(r_lfsr) : f_inc_word(c, 32'd1);
                end else if (w_hs) begin
                    r_cnt  <= r_cnt + 1'b1;
                    r_gcnt <= r_gap;
                    if (r_mode) begin
                        r_lfsr <= w_lfsr_nxt;
                        r_data <= f_lfsr_word(w_lfsr_nxt);
                    end else begin
                        r_data <= f_inc_word(c, 32'(r_cnt) + 32'd2);
                    end
                end else if (r_state == S_GAP) begin
                    r_gcnt <= r_gcnt - 1'b1;
                end
            end
        end

        assign w_idle_vec[c] = (r_state == S_IDLE);
        assign w_done_vec[c] = (r_state == S_DONE);
        assign o_fifo_vld[c] = (r_state == S_SEND);
        assign o_fifo_data[c*DATA_WIDTH +: DATA_WIDTH] = r_data;
    end

endmodule

// File: tb/tb_dg_multi_ch.sv
module tb_dg_multi_ch;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_start;
    logic         i_mode;
    logic [7:0]   i_pkt_num;
    logic [7:0]   i_gap;
    logic         o_busy;
    logic         o_done;
    logic [3:0]   i_fifo_ready;
    logic [3:0]   o_fifo_vld;
    logic [127:0] o_fifo_data;

    int n_pass  = 0;
    int n_total = 0;

    dg_multi_ch dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_mode       (i_mode),
        .i_pkt_num    (i_pkt_num),
        .i_gap        (i_gap),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .i_fifo_ready (i_fifo_ready),
        .o_fifo_vld   (o_fifo_vld),
        .o_fifo_data  (o_fifo_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  vld;
        logic [31:0] d0;
        logic [31:0] d2;
        logic        busy;
        logic        done;
    } row_t;

    row_t tbl[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mkw(input int wt, input int ln, input int pr, input int da);
        logic [31:0] w;
        w = ((32'(wt) & 32'h3FF) << 17) | ((32'(ln) & 32'h3FF) << 7)
          | ((32'(pr) & 32'h7) << 4) | (32'(da) & 32'hF);
        return w;
    endfunction

    // Reference incrementing descriptor, k is the 0-based index.
    function automatic logic [31:0] m_inc(input int c, input int k);
        int ln;
        ln = (1 + 10 * (k + 1)) & 1023;
        if (ln == 0) ln = 1;
        return mkw(20 + 10 * (k + 1), ln, k + 1, k + 1 + c);
    endfunction

    function automatic logic [15:0] m_lfsr_step(input logic [15:0] s);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    function automatic logic [31:0] m_lfsr_word(input logic [15:0] s);
        int ln;
        ln = int'(s[15:6]);
        if (ln == 0) ln = 1;
        return mkw(int'(s[9:0] ^ s[15:6]), ln, int'(s[6:4]), int'(s[3:0]));
    endfunction

    function automatic logic [31:0] ch_data(input int c);
        return o_fifo_data[c*32 +: 32];
    endfunction

    task automatic start_run(input logic mode, input logic [7:0] pkt, input logic [7:0] gap);
        i_mode    = mode;
        i_pkt_num = pkt;
        i_gap     = gap;
        i_start   = 1'b1;
        tick();
        i_start   = 1'b0;
    endtask

    task automatic run_table(input string tag, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            chk($sformatf("%s_vld[%0d]", tag, i - first), 32'(o_fifo_vld), 32'(tbl[i].vld));
            chk($sformatf("%s_busy[%0d]", tag, i - first), 32'(o_busy), 32'(tbl[i].busy));
            chk($sformatf("%s_done[%0d]", tag, i - first), 32'(o_done), 32'(tbl[i].done));
            if (tbl[i].vld[0]) chk($sformatf("%s_d0[%0d]", tag, i - first), ch_data(0), tbl[i].d0);
            if (tbl[i].vld[2]) chk($sformatf("%s_d2[%0d]", tag, i - first), ch_data(2), tbl[i].d2);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s [4];
        int          k [4];
        int          all3;
        logic        done_seen;
        logic        exp_v;

        // mode 0, pkt 3, gap 0: three back-to-back words, then done
        tbl[0]  = '{4'b1111, mkw(30, 11, 1, 1), mkw(30, 11, 1, 3), 1'b1, 1'b0};
        tbl[1]  = '{4'b1111, mkw(40, 21, 2, 2), mkw(40, 21, 2, 4), 1'b1, 1'b0};
        tbl[2]  = '{4'b1111, mkw(50, 31, 3, 3), mkw(50, 31, 3, 5), 1'b1, 1'b0};
        tbl[3]  = '{4'b0000, 32'h0, 32'h0, 1'b1, 1'b1};
        tbl[4]  = '{4'b0000, 32'h0, 32'h0, 1'b0, 1'b0};
        // mode 0, pkt 2, gap 3: one word, three idle cycles, one word
        tbl[5]  = '{4'b1111, mkw(30, 11, 1, 1), mkw(30, 11, 1, 3), 1'b1, 1'b0};
        tbl[6]  = '{4'b0000, 32'h0, 32'h0, 1'b1, 1'b0};
        tbl[7]  = '{4'b0000, 32'h0, 32'h0, 1'b1, 1'b0};
        tbl[8]  = '{4'b0000, 32'h0, 32'h0, 1'b1, 1'b0};
        tbl[9]  = '{4'b1111, mkw(40, 21, 2, 2), mkw(40, 21, 2, 4), 1'b1, 1'b0};
        tbl[10] = '{4'b0000, 32'h0, 32'h0, 1'b1, 1'b1};
        tbl[11] = '{4'b0000, 32'h0, 32'h0, 1'b0, 1'b0};

        rst = 1'b1; i_start = 1'b0; i_mode = 1'b0; i_pkt_num = '0; i_gap = '0;
        i_fifo_ready = 4'b1111;
        tick(); tick();
        chk("rst_vld", 32'(o_fifo_vld), 32'h0);
        chk("rst_data", o_fifo_data[31:0] | o_fifo_data[63:32] | o_fifo_data[95:64] | o_fifo_data[127:96], 32'h0);
        chk("rst_busy", 32'(o_busy), 32'h0);
        chk("rst_done", 32'(o_done), 32'h0);
        rst = 1'b0;
        tick();

        start_run(1'b0, 8'd3, 8'd0);
        run_table("inc", 0, 5);

        start_run(1'b0, 8'd2, 8'd3);
        run_table("gap", 5, 7);

        // zero descriptors: done and busy together for one cycle only
        start_run(1'b0, 8'd0, 8'd0);
        chk("p0_vld", 32'(o_fifo_vld), 32'h0);
        chk("p0_busy", 32'(o_busy), 32'h1);
        chk("p0_done", 32'(o_done), 32'h1);
        tick();
        chk("p0_busy_after", 32'(o_busy), 32'h0);
        chk("p0_done_after", 32'(o_done), 32'h0);
        chk("p0_vld_after", 32'(o_fifo_vld), 32'h0);

        // ch1 stalled for 5 cycles; an ignored start is pulsed mid-run
        start_run(1'b0, 8'd3, 8'd0);
        for (int c = 0; c < 4; c++) k[c] = 0;
        done_seen = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            all3 = (k[0] == 3 && k[1] == 3 && k[2] == 3 && k[3] == 3) ? 1 : 0;
            for (int c = 0; c < 4; c++) begin
                exp_v = (k[c] < 3);
                chk($sformatf("bp_vld_c%0d[%0d]", c, cyc), 32'(o_fifo_vld[c]), 32'(exp_v));
                if (exp_v) chk($sformatf("bp_data_c%0d[%0d]", c, cyc), ch_data(c), m_inc(c, k[c]));
            end
            chk($sformatf("bp_done[%0d]", cyc), 32'(o_done), 32'((all3 == 1) && !done_seen));
            chk($sformatf("bp_busy[%0d]", cyc), 32'(o_busy), 32'(!((all3 == 1) && done_seen)));
            if (all3 == 1) done_seen = 1'b1;
            i_fifo_ready = (cyc < 5) ? 4'b1101 : 4'b1111;
            if (cyc == 2) begin
                i_start = 1'b1; i_pkt_num = 8'd7; i_mode = 1'b1;
            end
            for (int c = 0; c < 4; c++)
                if (k[c] < 3 && i_fifo_ready[c]) k[c]++;
            tick();
            i_start = 1'b0;
        end
        i_fifo_ready = 4'b1111;

        // LFSR mode from fresh seeds
        rst = 1'b1; tick(); rst = 1'b0; tick();
        for (int c = 0; c < 4; c++) s[c] = 16'hACE1 + 16'(c);
        start_run(1'b1, 8'd4, 8'd0);
        for (int cyc = 0; cyc < 4; cyc++) begin
            chk($sformatf("lfsr_vld[%0d]", cyc), 32'(o_fifo_vld), 32'hF);
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("lfsr_data_c%0d[%0d]", c, cyc), ch_data(c), m_lfsr_word(s[c]));
                chk($sformatf("lfsr_len_nz_c%0d[%0d]", c, cyc), 32'(ch_data(c)[16:7] != 10'd0), 32'h1);
                s[c] = m_lfsr_step(s[c]);
            end
            tick();
        end
        chk("lfsr_done", 32'(o_done), 32'h1);
        chk("lfsr_vld_end", 32'(o_fifo_vld), 32'h0);
        tick();

        // reset mid-run, then restart from the first descriptor
        start_run(1'b0, 8'd5, 8'd0);
        tick();
        rst = 1'b1;
        #1;
        chk("mrst_vld", 32'(o_fifo_vld), 32'h0);
        chk("mrst_data", o_fifo_data[31:0] | o_fifo_data[63:32] | o_fifo_data[95:64] | o_fifo_data[127:96], 32'h0);
        chk("mrst_busy", 32'(o_busy), 32'h0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("mrst_idle_vld", 32'(o_fifo_vld), 32'h0);
        chk("mrst_idle_busy", 32'(o_busy), 32'h0);
        start_run(1'b0, 8'd5, 8'd0);
        chk("mrst_restart_vld", 32'(o_fifo_vld), 32'hF);
        for (int c = 0; c < 4; c++)
            chk($sformatf("mrst_restart_c%0d", c), ch_data(c), m_inc(c, 0));
        for (int i = 0; i < 5; i++) tick();
        chk("mrst_done", 32'(o_done), 32'h1);
        tick();
        chk("mrst_busy_end", 32'(o_busy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
